// File: rtl/inst_fifo_if.sv
// Handshake bundle between fetch (writer), issue (reader) and the instruction queue.
interface inst_fifo_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          flush;
    logic          write_en1;
    logic          write_en2;
    logic [DW-1:0] write_inst1;
    logic [DW-1:0] write_inst2;
    logic [AW-1:0] write_pc1;
    logic [AW-1:0] write_pc2;
    logic          read_en1;
    logic          read_en2;
    logic [DW-1:0] read_inst1;
    logic [DW-1:0] read_inst2;
    logic [AW-1:0] read_pc1;
    logic [AW-1:0] read_pc2;
    logic          read_valid1;
    logic          read_valid2;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic          fifo_full;

    // Queue side: takes writes and pop requests, presents head entries and status.
    modport slave (
        input  flush, write_en1, write_en2, write_inst1, write_inst2,
               write_pc1, write_pc2, read_en1, read_en2,
        output read_inst1, read_inst2, read_pc1, read_pc2,
               read_valid1, read_valid2, fifo_empty, fifo_almost_empty, fifo_full
    );

    // Pipeline side: fetch pushes, issue pops.
    modport master (
        output flush, write_en1, write_en2, write_inst1, write_inst2,
               write_pc1, write_pc2, read_en1, read_en2,
        input  read_inst1, read_inst2, read_pc1, read_pc2,
               read_valid1, read_valid2, fifo_empty, fifo_almost_empty, fifo_full
    );
endinterface

// File: rtl/inst_fifo.sv
// Dual-port instruction queue: up to two pushes and two pops per cycle,
// head and head+1 presented combinationally for master/slave issue.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic         clk,
    input  logic         resetn,
    inst_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          valid1_s;
    logic          valid2_s;
    logic          full_s;
    logic [PW-1:0] head_p1_s;
    logic [EW-1:0] entry1_s;
    logic [EW-1:0] entry2_s;
    logic [1:0]    pops_s;
    logic [1:0]    pushes_s;
    logic          wr0_en_s;
    logic          wr1_en_s;
    logic [PW-1:0] wr0_addr_s;
    logic [PW-1:0] wr1_addr_s;
    logic [EW-1:0] wr0_data_s;
    logic [EW-1:0] wr1_data_s;

    // Status decode of the registered occupancy and head-entry lookup.
    always_comb begin
        valid1_s  = (count_q != {CW{1'b0}});
        valid2_s  = (count_q >= CW'(2));
        full_s    = (count_q >= CW'(DEPTH - 1));
        head_p1_s = head_q + PW'(1);
        entry1_s  = mem_q[head_q];
        entry2_s  = mem_q[head_p1_s];
    end

    // Drive read ports; entries without a valid flag read as zero.
    always_comb begin
        bus.read_valid1       = valid1_s;
        bus.read_valid2       = valid2_s;
        bus.fifo_empty        = (count_q == {CW{1'b0}});
        bus.fifo_almost_empty = (count_q == CW'(1));
        bus.fifo_full         = full_s;
        if (valid1_s) begin
            bus.read_pc1   = entry1_s[EW-1:DW];
            bus.read_inst1 = entry1_s[DW-1:0];
        end else begin
            bus.read_pc1   = {AW{1'b0}};
            bus.read_inst1 = {DW{1'b0}};
        end
        if (valid2_s) begin
            bus.read_pc2   = entry2_s[EW-1:DW];
            bus.read_inst2 = entry2_s[DW-1:0];
        end else begin
            bus.read_pc2   = {AW{1'b0}};
            bus.read_inst2 = {DW{1'b0}};
        end
    end

    // Pop count: slave pop only rides along with a master pop, clipped to occupancy.
    always_comb begin
        pops_s = {1'b0, bus.read_en1 & valid1_s}
               + {1'b0, bus.read_en1 & bus.read_en2 & valid2_s};
    end

    // Compact the write slots onto tail/tail+1; drop everything when full or flushing.
    always_comb begin
        pushes_s   = 2'd0;
        wr0_en_s   = 1'b0;
        wr1_en_s   = 1'b0;
        wr0_addr_s = tail_q;
        wr1_addr_s = tail_q + PW'(1);
        wr0_data_s = {bus.write_pc1, bus.write_inst1};
        wr1_data_s = {bus.write_pc2, bus.write_inst2};
        if (!full_s && !bus.flush) begin
            case ({bus.write_en1, bus.write_en2})
                2'b11: begin
                    wr0_en_s = 1'b1;
                    wr1_en_s = 1'b1;
                    pushes_s = 2'd2;
                end
                2'b10: begin
                    wr0_en_s = 1'b1;
                    pushes_s = 2'd1;
                end
                2'b01: begin
                    wr0_en_s   = 1'b1;
                    wr0_data_s = {bus.write_pc2, bus.write_inst2};
                    pushes_s   = 2'd1;
                end
                default: begin
                    pushes_s = 2'd0;
                end
            endcase
        end else begin
            pushes_s = 2'd0;
        end
    end

    // Next pointer/occupancy state; flush wins over any traffic this cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            head_d  = head_q + PW'(pops_s);
            tail_d  = tail_q + PW'(pushes_s);
            count_d = count_q + CW'(pushes_s) - CW'(pops_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed behind the valid flags, so no reset.
    always_ff @(posedge clk) begin
        if (wr0_en_s) begin
            mem_q[wr0_addr_s] <= wr0_data_s;
        end
        if (wr1_en_s) begin
            mem_q[wr1_addr_s] <= wr1_data_s;
        end
    end
endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: directed vector table, corner-case sequences and
// random traffic compared against a queue-based reference model.
module tb_inst_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    inst_fifo_if #(.DW(DW), .AW(AW)) bus ();

    inst_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference contents, oldest first: {pc, inst}
    logic [63:0] model_q [$];

    typedef struct {
        logic        fl;
        logic        we1;
        logic        we2;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] p1;
        logic [31:0] p2;
        logic        re1;
        logic        re2;
        int          cnt;
        logic [31:0] e_inst1;
        logic [31:0] e_pc1;
        logic [31:0] e_inst2;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic we1, input logic we2,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] p1, input logic [31:0] p2,
                         input logic re1, input logic re2);
        bus.flush       = fl;
        bus.write_en1   = we1;
        bus.write_en2   = we2;
        bus.write_inst1 = i1;
        bus.write_inst2 = i2;
        bus.write_pc1   = p1;
        bus.write_pc2   = p2;
        bus.read_en1    = re1;
        bus.read_en2    = re2;
    endtask

    // Apply the current inputs to the reference model (one clock edge).
    task automatic model_step();
        int sz;
        int pops;
        sz = model_q.size();
        if (bus.flush) begin
            model_q.delete();
        end else begin
            pops = 0;
            if (bus.read_en1 && sz >= 1) pops = 1;
            if (bus.read_en1 && bus.read_en2 && sz >= 2) pops = 2;
            for (int k = 0; k < pops; k++) void'(model_q.pop_front());
            if (sz < DEPTH - 1) begin
                if (bus.write_en1) model_q.push_back({bus.write_pc1, bus.write_inst1});
                if (bus.write_en2) model_q.push_back({bus.write_pc2, bus.write_inst2});
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        logic [63:0] e1;
        logic [63:0] e2;
        sz = model_q.size();
        e1 = (sz >= 1) ? model_q[0] : 64'd0;
        e2 = (sz >= 2) ? model_q[1] : 64'd0;
        chk({tag, ".valid1"}, 32'(bus.read_valid1), 32'(sz >= 1));
        chk({tag, ".valid2"}, 32'(bus.read_valid2), 32'(sz >= 2));
        chk({tag, ".inst1"},  bus.read_inst1, e1[31:0]);
        chk({tag, ".pc1"},    bus.read_pc1,   e1[63:32]);
        chk({tag, ".inst2"},  bus.read_inst2, e2[31:0]);
        chk({tag, ".pc2"},    bus.read_pc2,   e2[63:32]);
        chk({tag, ".empty"},  32'(bus.fifo_empty),        32'(sz == 0));
        chk({tag, ".aempty"}, 32'(bus.fifo_almost_empty), 32'(sz == 1));
        chk({tag, ".full"},   32'(bus.fifo_full),         32'(sz >= DEPTH - 1));
    endtask

    initial begin
        logic [31:0] next_pc;
        logic [31:0] prev_pc;
        bit          have_prev;

        // fl we1 we2 i1 i2 p1 p2 re1 re2 | cnt inst1 pc1 inst2
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h24020001, 32'h0, 32'hBFC00000, 32'h0, 1'b0, 1'b0,
                  1, 32'h24020001, 32'hBFC00000, 32'h0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0, 32'h0, 32'h0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'h11, 32'h22, 32'hBFC00000, 32'hBFC00004, 1'b0, 1'b0,
                  2, 32'h11, 32'hBFC00000, 32'h22};
        vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1,
                  2, 32'h11, 32'hBFC00000, 32'h22};
        vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 0, 32'h0, 32'h0, 32'h0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'hAAAA, 32'h33, 32'h0, 32'h100, 1'b0, 1'b0,
                  1, 32'h33, 32'h100, 32'h0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 32'h44, 32'hDEAD, 32'h104, 32'h0, 1'b1, 1'b0,
                  1, 32'h44, 32'h104, 32'h0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 0, 32'h0, 32'h0, 32'h0};

        // Reset: assert asynchronously, check outputs while held and after release
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check_model("rst_hold");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        check_model("rst_rel");

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].fl, vt[i].we1, vt[i].we2, vt[i].i1, vt[i].i2,
                  vt[i].p1, vt[i].p2, vt[i].re1, vt[i].re2);
            tick();
            chk($sformatf("vec%0d.valid1", i), 32'(bus.read_valid1), 32'(vt[i].cnt >= 1));
            chk($sformatf("vec%0d.valid2", i), 32'(bus.read_valid2), 32'(vt[i].cnt >= 2));
            chk($sformatf("vec%0d.empty", i),  32'(bus.fifo_empty),  32'(vt[i].cnt == 0));
            chk($sformatf("vec%0d.aempty", i), 32'(bus.fifo_almost_empty), 32'(vt[i].cnt == 1));
            chk($sformatf("vec%0d.inst1", i),  bus.read_inst1, vt[i].e_inst1);
            chk($sformatf("vec%0d.pc1", i),    bus.read_pc1,   vt[i].e_pc1);
            chk($sformatf("vec%0d.inst2", i),  bus.read_inst2, vt[i].e_inst2);
            check_model($sformatf("vec%0d", i));
        end

        // Fill to 16 with dual writes, then check dropped writes while full
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(2 * c), 32'h1001 + 32'(2 * c),
                  32'h2000 + 32'(8 * c), 32'h2004 + 32'(8 * c), 1'b0, 1'b0);
            tick();
            chk($sformatf("fill%0d.full", c), 32'(bus.fifo_full), 32'(2 * (c + 1) >= 15));
            check_model($sformatf("fill%0d", c));
        end
        drive(1'b0, 1'b1, 1'b1, 32'hBAD0, 32'hBAD1, 32'hBAD0, 32'hBAD4, 1'b0, 1'b0);
        tick();
        chk("full16.inst1", bus.read_inst1, 32'h1000);
        chk("full16.full", 32'(bus.fifo_full), 32'd1);
        check_model("full16");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("full15.full", 32'(bus.fifo_full), 32'd1);
        chk("full15.inst1", bus.read_inst1, 32'h1001);
        drive(1'b0, 1'b1, 1'b1, 32'hBAD2, 32'hBAD3, 32'hBAD8, 32'hBADC, 1'b0, 1'b0);
        tick();
        check_model("full15_drop");
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
            tick();
            check_model($sformatf("drain%0d", c));
        end

        // Wrap-around: write 2 / pop 1 with incrementing PCs
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        next_pc   = 32'hBFC00000;
        prev_pc   = 32'h0;
        have_prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (model_q.size() < DEPTH - 1) begin
                drive(1'b0, 1'b1, 1'b1, next_pc ^ 32'h5A5A0000, (next_pc + 32'd4) ^ 32'h5A5A0000,
                      next_pc, next_pc + 32'd4, 1'b1, 1'b0);
                next_pc = next_pc + 32'd8;
            end else begin
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            end
            if (bus.read_valid1) begin
                if (have_prev) chk($sformatf("wrap%0d.pcseq", c), bus.read_pc1, prev_pc + 32'd4);
                prev_pc   = bus.read_pc1;
                have_prev = 1'b1;
            end
            tick();
            check_model($sformatf("wrap%0d", c));
        end

        // Flush mid-stream with concurrent dual write and dual read
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h50 + 32'(c), 32'h60 + 32'(c),
                  32'h400 + 32'(8 * c), 32'h404 + 32'(8 * c), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h70, 32'h0, 32'h418, 32'h0, 1'b0, 1'b0);
        tick();
        check_model("pre_flush");
        drive(1'b1, 1'b1, 1'b1, 32'hF1, 32'hF2, 32'h500, 32'h504, 1'b1, 1'b1);
        tick();
        chk("flush.empty", 32'(bus.fifo_empty), 32'd1);
        chk("flush.valid1", 32'(bus.read_valid1), 32'd0);
        check_model("flush");
        drive(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 32'h300, 32'h0, 1'b0, 1'b0);
        tick();
        chk("post_flush.inst1", bus.read_inst1, 32'h77);
        chk("post_flush.pc1", bus.read_pc1, 32'h300);
        check_model("post_flush");

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom));
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
